algo_engine_sched: RTL and testbench
====================================

# algo_engine_sched

Round-robin scheduler sharing one algorithmic engine (the sort/unique-elements datapath with `Ld`/`En`/`done`/`count`) among several requesters. It grants one requester at a time and sequences the engine through load, enable and completion. It returns the engine's result count, or a timeout error, on a single response channel. It sits between the requester agents and the engine instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters. Legal range is 2..16.
- `COUNT_W`, 32: width of the engine result count.
- `TIMEOUT`, 4096: maximum RUN cycles before the job is aborted. Must be ≥ 2.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req` in `NUM_REQ`: per-requester job request, level.
- `gnt` out `NUM_REQ`: one-hot grant. Held from LOAD through the response handshake.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted.
- `rsp_id` out `ID_W`: index of the served requester.
- `rsp_count` out `COUNT_W`: engine count. 0 on error.
- `rsp_err` out 1: timeout flag.
- `eng_ld` out 1: engine load strobe.
- `eng_en` out 1: engine enable.
- `eng_done` in 1: engine completion. May remain high after a job finishes.
- `eng_count` in `COUNT_W`: engine result.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD, START, RUN, RESP.
- **IDLE**: if `req` is non-zero, the rr pick selects the winner, scanning from `ptr` upward with wrap. On the next edge `gnt[winner]` is set, `rsp_id` is set to the winner, and the FSM moves to LOAD. If `req` is zero, stay in IDLE.
- **LOAD**: `eng_ld`=1 for exactly one cycle, then go to START.
- **START**: `eng_en`=1 and `timer` is cleared, then go to RUN.
- **RUN**: `eng_en`=1 and `timer`++ each cycle.
  - `eng_done` is ignored in LOAD, START and the first RUN cycle (`timer`==0). This guards against a stale done from the previous job.
  - `eng_done` with `timer`≥1: capture `eng_count` into `rsp_count`, set `rsp_err`=0, go to RESP.
  - Otherwise, when `timer`==`TIMEOUT`-1: set `rsp_count`=0, `rsp_err`=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- **RESP**: `eng_en`=0 and `rsp_valid`=1.
  - `rsp_id`, `rsp_count` and `rsp_err` are held stable until `rsp_valid && rsp_ready`.
  - On the handshake: clear `gnt` and `rsp_valid`, set `ptr` to (winner+1) mod `NUM_REQ`, go to IDLE.
- A requester dropping `req` mid-job is ignored. The job completes and its response is still delivered.
- New requests are only sampled in IDLE. This gives one bubble cycle between jobs.
- `eng_ld` and `eng_en` are never high together.
- `ID_W` = max(1, clog2(`NUM_REQ`)). `timer` width = clog2(`TIMEOUT`)+1 and it must not wrap.
- Reset (`rst`=0 at an edge) applies in any state, including mid-RUN or RESP:
  - FSM goes to IDLE and `ptr` to 0.
  - `gnt`, `rsp_valid`, `rsp_id`, `rsp_count`, `rsp_err`, `eng_ld`, `eng_en`, `busy` and `timer` all go to 0.
  - The in-flight job is discarded with no response.

## Timing
- All outputs are registered.
- With `req` sampled at edge k in IDLE:
  - k+1: `gnt` and `eng_ld`.
  - k+2: `eng_en` (START).
  - k+3: first RUN cycle.
- `eng_done` sampled at edge d in RUN gives `rsp_valid` at d+1.
- Handshake at edge r gives IDLE at r+1. The earliest next `gnt` is r+2.
- The fastest job is 5 cycles from request to `rsp_valid`, with the engine done by the second RUN cycle.
- A timeout job asserts `rsp_valid` exactly `TIMEOUT` RUN cycles after START.

## Structure
- Shared package `algo_ctrl_pkg` holds:
  - the state enum `sched_state_t` {IDLE, LOAD, START, RUN, RESP};
  - the `ID_W` derivation function;
  - the default `TIMEOUT` constant, shared with the other algorithmic controllers.
- One sub-module, `rr_pick`: combinational, takes `req` and `ptr` and returns a one-hot winner plus its index. It is reusable by other engine schedulers.
- The FSM, timer and response registers stay in `algo_engine_sched`.

## Test plan
- **Single job**: `NUM_REQ`=4, `req`=0010, engine model asserts done after 20 cycles with count=5.
  - `gnt`=0010 at k+1 and `eng_ld` high for one cycle.
  - Response `rsp_id`=1, `rsp_count`=5, `rsp_err`=0.
- **Fairness**: `req`=1111 held, `rsp_ready`=1.
  - Grant order 0,1,2,3,0,1.
  - Exactly one bubble cycle between consecutive jobs.
- **Timeout**: `TIMEOUT`=16, `eng_done` held 0.
  - `rsp_err`=1 and `rsp_count`=0, 16 cycles after START.
  - `eng_en` low in RESP.
  - Next job is granted normally.
- **Stale done**: `eng_done` held 1 across the LOAD boundary.
  - No acceptance in LOAD, START or RUN cycle 1.
  - Accepted on RUN cycle 2, giving `rsp_valid` exactly 5 cycles after the request.
- **Backpressure**: `rsp_ready`=0 for 10 cycles while `req`=1111.
  - `rsp_valid`, `rsp_id` and `rsp_count` stable.
  - `gnt` unchanged and no `eng_ld` until the handshake.
- **Reset mid-RUN**: `rst`=0 for one edge during RUN.
  - All outputs 0 at the next cycle.
  - After release with `req`=1001, requester 0 is granted first, since `ptr` was reset.

Source files
------------

// File: rtl/algo_ctrl_pkg.sv
// Shared definitions for the algorithmic-engine controllers: scheduler state
// encoding, requester-index width helper and the default run timeout.
package algo_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      RUN   = 3'd3,
      RESP  = 3'd4
   } sched_state_t;

   localparam int ALGO_TIMEOUT_DEF = 4096;

   // Index width for n requesters, never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: scans req starting at ptr, wrapping, and returns the
// first asserted requester as one-hot plus its index.
module rr_pick
   import algo_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   // Rotating priority scan; the first hit from ptr upward wins.
   always_comb begin
      winner = '0;
      idx    = '0;
      any    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int j;
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any && req[j]) begin
            any       = 1'b1;
            winner[j] = 1'b1;
            idx       = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/algo_engine_sched.sv
// Round-robin scheduler for a shared sort/unique engine. Grants one requester,
// strobes load, enables the engine until done or timeout, then returns the
// count (or a timeout error) on a valid/ready response channel.
//
// state | meaning
// IDLE  | waiting for any request; picks the next winner round-robin
// LOAD  | engine load strobe for one cycle
// START | engine enabled, run timer cleared
// RUN   | engine enabled, waiting for done (ignored while timer==0) or timeout
// RESP  | response presented, held until accepted
module algo_engine_sched
   import algo_ctrl_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int COUNT_W = 32,
   parameter  int TIMEOUT = ALGO_TIMEOUT_DEF,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [COUNT_W-1:0] rsp_count,
   output logic               rsp_err,
   output logic               eng_ld,
   output logic               eng_en,
   input  logic               eng_done,
   input  logic [COUNT_W-1:0] eng_count,
   output logic               busy
);

   localparam int TMR_W = $clog2(TIMEOUT) + 1;

   sched_state_t       state_q;
   sched_state_t       state_d;
   logic [TMR_W-1:0]   timer;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    ptr_next;
   logic [NUM_REQ-1:0] pick_oh;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic               take_job;
   logic               fin_ok;
   logic               fin_err;
   logic               handshake;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Pointer moves just past the requester that was served.
   assign ptr_next = (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;

   // Next-state decode and the per-cycle events that drive the registers.
   always_comb begin
      state_d   = state_q;
      take_job  = 1'b0;
      fin_ok    = 1'b0;
      fin_err   = 1'b0;
      handshake = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               take_job = 1'b1;
               state_d  = LOAD;
            end
         end
         LOAD:  state_d = START;
         START: state_d = RUN;
         RUN: begin
            // A done seen while timer==0 may be left over from the previous job.
            if (eng_done && (timer != '0)) begin
               fin_ok  = 1'b1;
               state_d = RESP;
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
               fin_err = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               handshake = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Registered outputs, grant/pointer bookkeeping, run timer and response data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt       <= '0;
         ptr       <= '0;
         timer     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_count <= '0;
         rsp_err   <= 1'b0;
         eng_ld    <= 1'b0;
         eng_en    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         eng_ld    <= (state_d == LOAD);
         eng_en    <= (state_d == START) || (state_d == RUN);
         rsp_valid <= (state_d == RESP);
         busy      <= (state_d != IDLE);
         if (take_job) begin
            gnt    <= pick_oh;
            rsp_id <= pick_idx;
         end
         if (handshake) begin
            gnt <= '0;
            ptr <= ptr_next;
         end
         if (state_q == START) timer <= '0;
         else if ((state_q == RUN) && (state_d == RUN)) timer <= timer + 1'b1;
         if (fin_ok) begin
            rsp_count <= eng_count;
            rsp_err   <= 1'b0;
         end else if (fin_err) begin
            rsp_count <= '0;
            rsp_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_algo_engine_sched.sv
// Directed bench for algo_engine_sched. A main instance (TIMEOUT=64) covers
// single job, stale done, fairness, backpressure and reset mid-RUN; a second
// instance (TIMEOUT=16) covers the timeout path.
module tb_algo_engine_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, gnt;
   logic        rsp_valid, rsp_ready, rsp_err, eng_ld, eng_en, eng_done, busy;
   logic [1:0]  rsp_id;
   logic [31:0] rsp_count, eng_count;

   logic [3:0]  req_t, gnt_t;
   logic        rsp_valid_t, rsp_ready_t, rsp_err_t, eng_ld_t, eng_en_t, eng_done_t, busy_t;
   logic [1:0]  rsp_id_t;
   logic [31:0] rsp_count_t, eng_count_t;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   algo_engine_sched #(.NUM_REQ(4), .COUNT_W(32), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_count(rsp_count),
      .rsp_err(rsp_err), .eng_ld(eng_ld), .eng_en(eng_en), .eng_done(eng_done),
      .eng_count(eng_count), .busy(busy)
   );

   algo_engine_sched #(.NUM_REQ(4), .COUNT_W(32), .TIMEOUT(16)) dut_t (
      .clk(clk), .rst(rst), .req(req_t), .gnt(gnt_t), .rsp_valid(rsp_valid_t),
      .rsp_ready(rsp_ready_t), .rsp_id(rsp_id_t), .rsp_count(rsp_count_t),
      .rsp_err(rsp_err_t), .eng_ld(eng_ld_t), .eng_en(eng_en_t), .eng_done(eng_done_t),
      .eng_count(eng_count_t), .busy(busy_t)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int oh2i(input logic [3:0] v);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      int n;
      int run_cyc;
      int grants[6];
      int exp_order[6];
      int ng, gap, gaps_bad, both;
      logic [3:0] prev;
      logic stable, early;

      rst = 1'b0; req = '0; rsp_ready = 1'b1; eng_done = 1'b0; eng_count = '0;
      req_t = '0; rsp_ready_t = 1'b0; eng_done_t = 1'b0; eng_count_t = '0;
      tick(); tick();

      // Reset state
      chk("rst_gnt", gnt, 4'b0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ld_en", {eng_ld, eng_en}, 2'b00);
      chk("rst_rsp", {rsp_id, rsp_err, rsp_count}, 0);
      rst = 1'b1;
      tick();

      // Single job: requester 1, done after 20 enabled cycles, count 5
      req = 4'b0010;
      tick();
      chk("single_gnt", gnt, 4'b0010);
      chk("single_ld", eng_ld, 1);
      chk("single_en_in_load", eng_en, 0);
      chk("single_busy", busy, 1);
      req = 4'b0000;
      tick();
      chk("single_ld_one_cycle", eng_ld, 0);
      chk("single_en_start", eng_en, 1);
      early = 1'b0;
      for (int i = 0; i < 19; i++) begin
         tick();
         if (rsp_valid) early = 1'b1;
      end
      chk("single_no_early_rsp", early, 0);
      eng_done = 1'b1; eng_count = 32'd5;
      tick();
      chk("single_valid", rsp_valid, 1);
      chk("single_id", rsp_id, 2'd1);
      chk("single_count", rsp_count, 32'd5);
      chk("single_err", rsp_err, 0);
      chk("single_en_resp", eng_en, 0);
      chk("single_gnt_held", gnt, 4'b0010);
      eng_done = 1'b0;
      tick();
      chk("single_hs_valid", rsp_valid, 0);
      chk("single_hs_gnt", gnt, 4'b0);

      // Stale done held high across LOAD: accepted only on second RUN cycle
      eng_done = 1'b1; eng_count = 32'd7;
      req = 4'b0100;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (rsp_valid) break;
      end
      chk("stale_latency", n, 5);
      chk("stale_id", rsp_id, 2'd2);
      chk("stale_count", rsp_count, 32'd7);
      req = 4'b0000;
      tick();

      // Fairness from ptr=0 after a reset pulse
      rst = 1'b0; tick(); rst = 1'b1;
      eng_done = 1'b1; rsp_ready = 1'b1; req = 4'b1111;
      exp_order = '{0, 1, 2, 3, 0, 1};
      ng = 0; gap = 0; gaps_bad = 0; both = 0; prev = '0;
      for (int c = 0; c < 80 && ng < 6; c++) begin
         tick();
         if (eng_ld && eng_en) both++;
         if (gnt != 4'b0 && prev == 4'b0) begin
            if (ng > 0 && gap != 1) gaps_bad++;
            grants[ng] = oh2i(gnt);
            ng++;
            gap = 0;
         end else if (gnt == 4'b0) begin
            gap++;
         end
         prev = gnt;
      end
      chk("fair_num_grants", ng, 6);
      for (int i = 0; i < 6; i++) chk($sformatf("fair_order_%0d", i), grants[i], exp_order[i]);
      chk("fair_one_bubble", gaps_bad, 0);
      chk("fair_ld_en_exclusive", both, 0);
      req = 4'b0000;
      for (int i = 0; i < 20 && busy; i++) tick();
      chk("fair_drain_idle", busy, 0);

      // Backpressure: ptr=2, so requester 2 is served and held
      req = 4'b1111; rsp_ready = 1'b0; eng_count = 32'd9;
      for (int i = 0; i < 12 && !rsp_valid; i++) tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 2'd2);
      chk("bp_count", rsp_count, 32'd9);
      eng_count = 32'd3;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!(rsp_valid && rsp_id == 2'd2 && rsp_count == 32'd9 &&
               gnt == 4'b0100 && !eng_ld)) stable = 1'b0;
      end
      chk("bp_stable", stable, 1);
      rsp_ready = 1'b1;
      tick();
      chk("bp_hs_valid", rsp_valid, 0);
      chk("bp_hs_gnt", gnt, 4'b0);
      tick();
      chk("bp_next_gnt", gnt, 4'b1000);
      chk("bp_next_ld", eng_ld, 1);

      // Reset mid-RUN, then ptr restarts at 0
      tick();
      tick();
      chk("mid_run_en", eng_en, 1);
      rst = 1'b0; req = 4'b1001;
      tick();
      chk("mrst_gnt", gnt, 4'b0);
      chk("mrst_ctrl", {rsp_valid, eng_ld, eng_en, busy, rsp_err}, 5'b0);
      chk("mrst_rsp", {rsp_id, rsp_count}, 0);
      rst = 1'b1;
      tick();
      chk("mrst_regrant", gnt, 4'b0001);
      chk("mrst_regrant_id", rsp_id, 2'd0);
      for (int i = 0; i < 12 && !rsp_valid; i++) tick();
      chk("mrst_job_valid", rsp_valid, 1);
      chk("mrst_job_count", rsp_count, 32'd3);
      req = 4'b0000;
      tick();

      // Timeout on the TIMEOUT=16 instance: 16 RUN cycles after START
      req_t = 4'b0001; eng_done_t = 1'b0;
      tick();
      chk("to_gnt", gnt_t, 4'b0001);
      req_t = 4'b0000;
      tick();
      chk("to_start_en", eng_en_t, 1);
      run_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (rsp_valid_t) break;
         run_cyc++;
      end
      chk("to_run_cycles", run_cyc, 16);
      chk("to_valid", rsp_valid_t, 1);
      chk("to_err", rsp_err_t, 1);
      chk("to_count", rsp_count_t, 32'd0);
      chk("to_en_low", eng_en_t, 0);
      rsp_ready_t = 1'b1;
      tick();
      chk("to_hs_gnt", gnt_t, 4'b0);
      req_t = 4'b0010; eng_done_t = 1'b1; eng_count_t = 32'd11;
      tick();
      chk("to_next_gnt", gnt_t, 4'b0010);
      chk("to_next_ld", eng_ld_t, 1);
      for (int i = 0; i < 12 && !rsp_valid_t; i++) tick();
      chk("to_next_err", rsp_err_t, 0);
      chk("to_next_count", rsp_count_t, 32'd11);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
